delay_line_controller: RTL and testbench

Sequencer and access port for one serial recirculating delay-line store of STORE_LEN words of WORD_WIDTH bits.
- Tracks which word and bit is currently at the line's output head.
- Waits for the addressed word to come round, then serially reads or overwrites it by driving the line's gate and clear inputs.
- Presents a simple req/ack parallel-word interface to the order-processing logic.

---
 rtl/delay_line_controller.sv | 160 ++++++++++++++++
 tb/tb_delay_line_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_controller.sv
// Purpose: sequencer/access port for one serial recirculating delay-line store (optional DLC_READ_AFTER_WRITE_EN: writes return the old word).
// Latency: access WORD_WIDTH .. STORE_LEN*WORD_WIDTH+WORD_WIDTH-1 edges, clear STORE_LEN*WORD_WIDTH, address error 2.
// Backpressure: req is only sampled in IDLE; busy covers the accept edge up to the ack edge, requests meanwhile are ignored.
module delay_line_controller #(
  parameter int STORE_LEN  = 16,
  parameter int WORD_WIDTH = 36,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] rdata,
  input  logic                  dl_data_out,
  output logic                  dl_data_in,
  output logic                  dl_data_in_gate,
  output logic                  dl_data_clr
);

  localparam int BW    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int TOTAL = STORE_LEN * WORD_WIDTH;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [BW-1:0]         LAST_BIT  = BW'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(STORE_LEN - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_EXT   = (ADDR_WIDTH + 1)'(STORE_LEN);
  localparam logic [CW-1:0]         CLR_LAST  = CW'(TOTAL - 1);
  localparam logic [CW-1:0]         ERR_LAST  = CW'(1);

  typedef enum logic [2:0] {IDLE, SEEK, XFER, CLEAR, ERR} state_t;

  state_t                  state, state_nxt;
  logic [BW-1:0]           head_bit, nxt_bit;
  logic [ADDR_WIDTH-1:0]   head_word, nxt_word;
  logic                    bit_wrap;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    we_reg;
  logic [WORD_WIDTH-1:0]   wdata_reg;
  logic [CW-1:0]           cnt;
  logic [WORD_WIDTH-1:0]   rdata_shift, captured;
  logic                    accept, done, cap_en;

  // Position that will be at the line head after the coming edge.
  assign bit_wrap = (head_bit == LAST_BIT);
  assign nxt_bit  = bit_wrap ? '0 : head_bit + 1'b1;
  assign nxt_word = bit_wrap ? ((head_word == LAST_WORD) ? '0 : head_word + 1'b1) : head_word;

`ifdef DLC_READ_AFTER_WRITE_EN
  // Every transfer samples the head, so a write also returns the word it overwrites.
  assign cap_en = 1'b1;
`else
  // Only reads sample the head; writes leave rdata alone.
  assign cap_en = ~we_reg;
`endif

  // Line-side signals follow state and head position with no register stage.
  assign dl_data_in_gate = (state == XFER) && we_reg;
  assign dl_data_in      = wdata_reg[head_bit];
  assign dl_data_clr     = (state != CLEAR);
  assign busy            = (state != IDLE);

  // Head tracker: free-running position of the line, zeroed at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_bit  <= '0;
      head_word <= '0;
    end else begin
      head_bit  <= nxt_bit;
      head_word <= nxt_word;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: wait for the addressed word to reach the head, then stream it.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (clr)                                      state_nxt = CLEAR;
          else if ({1'b0, addr} >= LEN_EXT)             state_nxt = ERR;
          else if (nxt_bit == '0 && nxt_word == addr)   state_nxt = XFER;
          else                                          state_nxt = SEEK;
        end
      end
      SEEK: begin
        if (nxt_bit == '0 && nxt_word == addr_reg) state_nxt = XFER;
      end
      XFER: begin
        if (bit_wrap) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        if (cnt == CLR_LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        if (cnt == ERR_LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word assembled so far, including the bit sitting at the head right now.
  always_comb begin
    captured           = rdata_shift;
    captured[head_bit] = dl_data_out;
  end

  // Request latch, cycle counter, serial capture and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      cnt         <= '0;
      rdata_shift <= '0;
      rdata       <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
    end else begin
      ack <= done;
      err <= done && (state == ERR);
      if (accept) begin
        addr_reg  <= addr;
        we_reg    <= we;
        wdata_reg <= wdata;
        cnt       <= '0;
      end else if (state == CLEAR || state == ERR) begin
        cnt <= cnt + 1'b1;
      end
      if (state == XFER && cap_en) begin
        rdata_shift[head_bit] <= dl_data_out;
        if (done) rdata <= captured;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_controller.sv
// Bench for delay_line_controller: bit-level delay line, word-level reference store with
// arithmetic latency prediction, per-cycle compare, plus directed literal checks.
module tb_delay_line_controller;

  localparam int SL    = 16;
  localparam int WW    = 36;
  localparam int AW    = 4;
  localparam int TOTAL = SL * WW;
  localparam int LIMIT = TOTAL + WW + 8;

  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_CLR = 2;
  localparam int K_ERR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, we = 1'b0, clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [WW-1:0] wdata = '0;
  logic          ack, err, busy;
  logic [WW-1:0] rdata;
  logic          dl_data_out, dl_data_in, dl_data_in_gate, dl_data_clr;

  logic          req12 = 1'b0;
  logic          ack12, err12, busy12;
  logic [WW-1:0] rdata12;
  logic          din12, gate12, clr_n12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delay_line_controller #(.STORE_LEN(SL), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .clr(clr), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .busy(busy), .rdata(rdata),
    .dl_data_out(dl_data_out), .dl_data_in(dl_data_in),
    .dl_data_in_gate(dl_data_in_gate), .dl_data_clr(dl_data_clr)
  );

  // Short store, used only to exercise the out-of-range address path.
  delay_line_controller #(.STORE_LEN(12), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .req(req12), .we(1'b1), .clr(1'b0), .addr(4'hF),
    .wdata({WW{1'b1}}), .ack(ack12), .err(err12), .busy(busy12), .rdata(rdata12),
    .dl_data_out(1'b0), .dl_data_in(din12), .dl_data_in_gate(gate12), .dl_data_clr(clr_n12)
  );

  // Delay line: one bit per position, head advances every edge.
  bit line_mem [TOTAL];
  int pos;
  assign dl_data_out = line_mem[pos];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos <= 0;
    else begin
      if (!dl_data_clr)        line_mem[pos] <= 1'b0;
      else if (dl_data_in_gate) line_mem[pos] <= dl_data_in;
      pos <= (pos == TOTAL - 1) ? 0 : pos + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: word store, completion edge computed from the head position at accept.
  bit [WW-1:0] ref_mem [SL];
  bit [WW-1:0] m_rdata, m_wdata;
  bit          m_busy, m_ack, m_err;
  int          cyc, m_deadline, m_kind, m_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_busy = 0; m_ack = 0; m_err = 0; m_rdata = '0;
    end else begin
      cyc++;
      m_ack = 0; m_err = 0;
      if (m_busy) begin
        if (cyc == m_deadline) begin
          m_busy = 0; m_ack = 1;
          case (m_kind)
            K_RD: m_rdata = ref_mem[m_addr];
            K_WR: begin
`ifdef DLC_READ_AFTER_WRITE_EN
              m_rdata = ref_mem[m_addr];
`endif
              ref_mem[m_addr] = m_wdata;
            end
            K_CLR: for (int i = 0; i < SL; i++) ref_mem[i] = '0;
            default: m_err = 1;
          endcase
        end
      end else if (req) begin
        m_busy  = 1;
        m_addr  = int'(addr);
        m_wdata = wdata;
        if (clr) begin
          m_kind = K_CLR; m_deadline = cyc + TOTAL;
        end else if (m_addr >= SL) begin
          m_kind = K_ERR; m_deadline = cyc + 2;
        end else begin
          m_kind = we ? K_WR : K_RD;
          m_deadline = cyc + ((m_addr * WW - (cyc % TOTAL) + TOTAL) % TOTAL) + WW;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the reference.
  int rem_c;
  always @(negedge clk) begin
    if (rst_n) begin
      rem_c = m_deadline - cyc;
      chk("ack",   64'(ack),   64'(m_ack));
      chk("err",   64'(err),   64'(m_err));
      chk("busy",  64'(busy),  64'(m_busy));
      chk("rdata", 64'(rdata), 64'(m_rdata));
      chk("gate",  64'(dl_data_in_gate), 64'(m_busy && m_kind == K_WR && rem_c >= 1 && rem_c <= WW));
      chk("clr_n", 64'(dl_data_clr),     64'(!(m_busy && m_kind == K_CLR)));
      chk("gate12", 64'(gate12),  64'(0));
      chk("clr12",  64'(clr_n12), 64'(1));
    end
  end

  task automatic wait_pos(input int p);
    int n = 0;
    while (pos != p && n < TOTAL + 4) begin
      @(negedge clk);
      n++;
    end
    if (pos != p) begin
      errors++;
      $display("FAIL wait_pos: got %0d expected %0d", pos, p);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the ack cycle.
  task automatic access(input bit w, input bit c, input logic [AW-1:0] a, input logic [WW-1:0] d,
                        output int lat, output logic [WW-1:0] rd, output logic e);
    we = w; clr = c; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    while (!ack && lat < LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!ack) begin
      errors++;
      $display("FAIL ack_timeout: got no ack after %0d edges, required ack", lat);
    end
    rd = rdata;
    e  = err;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [WW-1:0] rd, d;
    logic e;
    bit w, c;

    repeat (3) @(negedge clk);
    chk("rst_ack",   64'(ack),   64'(0));
    chk("rst_err",   64'(err),   64'(0));
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_gate",  64'(dl_data_in_gate), 64'(0));
    chk("rst_clr_n", 64'(dl_data_clr),     64'(1));
    rst_n = 1'b1;

    // Read addr 0 accepted exactly as (0,0) becomes the head: minimum latency.
    wait_pos(TOTAL - 1);
    access(1'b0, 1'b0, 4'd0, '0, lat, rd, e);
    chk("rd0_lat",   64'(lat), 64'(36));
    chk("rd0_rdata", 64'(rd),  64'(0));
    chk("rd0_err",   64'(e),   64'(0));

    // Write then read back, neighbours untouched.
    access(1'b1, 1'b0, 4'd5, 36'h8_0000_0001, lat, rd, e);
    access(1'b0, 1'b0, 4'd5, '0, lat, rd, e);
    chk("rd5", 64'(rd), 64'(36'h8_0000_0001));
    access(1'b0, 1'b0, 4'd4, '0, lat, rd, e);
    chk("rd4", 64'(rd), 64'(0));
    access(1'b0, 1'b0, 4'd6, '0, lat, rd, e);
    chk("rd6", 64'(rd), 64'(0));

    // Request one edge after (3,0) passed the head: maximum latency.
    wait_pos(3 * WW);
    access(1'b0, 1'b0, 4'd3, '0, lat, rd, e);
    chk("max_lat", 64'(lat), 64'(611));

    // Fill the store, clear it, everything reads back zero.
    for (int i = 0; i < SL; i++) begin
      d = {4'(i), 32'hC0DE_0000 + 32'(i) + 32'd1};
      access(1'b1, 1'b0, AW'(i), d, lat, rd, e);
    end
    access(1'b0, 1'b0, 4'd9, '0, lat, rd, e);
    chk("rd9_filled", 64'(rd), 64'({4'd9, 32'hC0DE_000A}));
    access(1'b0, 1'b1, 4'd0, '0, lat, rd, e);
    chk("clr_lat", 64'(lat), 64'(576));
    for (int i = 0; i < SL; i++) begin
      access(1'b0, 1'b0, AW'(i), '0, lat, rd, e);
      chk("rd_after_clr", 64'(rd), 64'(0));
    end

    // Out-of-range address on the 12-word instance.
    @(negedge clk);
    req12 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req12 = 1'b0;
    chk("err12_busy", 64'(busy12), 64'(1));
    chk("err12_noack_at_accept", 64'(ack12), 64'(0));
    n = 0;
    while (!ack12 && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("err12_lat",   64'(n),       64'(2));
    chk("err12_err",   64'(err12),   64'(1));
    chk("err12_rdata", 64'(rdata12), 64'(0));

    // Random traffic, including back-to-back acceptance in the ack cycle.
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      c = ($urandom_range(0, 15) == 0);
      w = 1'($urandom_range(0, 1));
      d = WW'({$urandom, $urandom});
      access(w, c, AW'($urandom_range(0, SL - 1)), d, lat, rd, e);
      if (c) chk("rand_clr_lat", 64'(lat), 64'(TOTAL));
    end

`ifdef DLC_READ_AFTER_WRITE_EN
    access(1'b1, 1'b0, 4'd2, 36'h1234, lat, rd, e);
    access(1'b1, 1'b0, 4'd2, '0, lat, rd, e);
    chk("raw_old_word", 64'(rd), 64'(36'h1234));
`endif

    // Reset in the middle of a write transfer.
    @(negedge clk);
    we = 1'b1; clr = 1'b0; addr = 4'd7; wdata = {WW{1'b1}}; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!dl_data_in_gate && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_gate_seen", 64'(dl_data_in_gate), 64'(1));
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy",  64'(busy),            64'(0));
    chk("rst_mid_gate",  64'(dl_data_in_gate), 64'(0));
    chk("rst_mid_ack",   64'(ack),             64'(0));
    chk("rst_mid_rdata", 64'(rdata),           64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_ack", 64'(ack), 64'(0));
    access(1'b0, 1'b1, 4'd0, '0, lat, rd, e);
    access(1'b0, 1'b0, 4'd7, '0, lat, rd, e);
    chk("rd7_after_rst_clr", 64'(rd), 64'(0));

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
